// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM states, oversampling constants
// and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    localparam int unsigned OVS     = 16;
    localparam int unsigned VOTE_LO = 7;
    localparam int unsigned VOTE_HI = 9;

    // Rounded clk cycles per oversampling tick, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = (clk_freq + baud * 8) / (baud * 16);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick divider with a synchronous clear, so the
// receiver can phase-align sampling to the start edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver (8N1) with mid-bit majority voting feeding the
// game's byte bus. Define UART_PARITY_EN for 8E1 framing with a parity_err output.
module uart_rx #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned WR_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       wr,
    output logic       frame_err,
`ifdef UART_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    import uart_pkg::*;

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);

    uart_state_t state, state_nxt;
    logic        rx_m, rx_s;
    logic        clr_div, tick;
    logic [3:0]  scnt;
    logic [2:0]  bcnt;
    logic [7:0]  shreg;
    logic [1:0]  samp;
    logic [3:0]  wr_cnt;
    logic        vote, at_vote, at_end;
    logic        good_stop, bad_stop, accept;

    // Synchronizer resets to the idle level so reset release cannot fake a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr_div),
        .tick (tick)
    );

    assign vote    = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
    assign at_vote = tick && (scnt == 4'(VOTE_HI));
    assign at_end  = tick && (scnt == 4'(OVS - 1));
    assign busy    = (state != IDLE);
    assign wr      = (wr_cnt != 4'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_div   = 1'b0;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    clr_div   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (at_vote && vote) begin
                    state_nxt = IDLE;
                end else if (at_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_end && bcnt == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
                if (at_end) begin
                    state_nxt = STOP;
                end
            end
            // Leave at the stop-bit vote, half a bit early, so a back-to-back start edge is caught.
            STOP: begin
                if (at_vote) begin
                    if (vote) begin
                        good_stop = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic par_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == PARITY && at_vote) begin
                par_bad    <= vote ^ (^shreg);
                parity_err <= vote ^ (^shreg);
            end
        end
    end

    assign accept = good_stop && !par_bad;
`else
    assign accept = good_stop;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            samp      <= '1;
            data      <= '0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (clr_div) begin
                scnt <= '0;
            end else if (tick && state != IDLE) begin
                scnt <= scnt + 4'd1;
            end

            if (tick && scnt == 4'(VOTE_LO)) begin
                samp[1] <= rx_s;
            end
            if (tick && scnt == 4'(VOTE_LO + 1)) begin
                samp[0] <= rx_s;
            end

            if (state == DATA && at_vote) begin
                shreg <= {vote, shreg[7:1]};
            end

            if (state == START && at_end) begin
                bcnt <= '0;
            end else if (state == DATA && at_end) begin
                bcnt <= bcnt + 3'd1;
            end

            if (accept) begin
                data   <= shreg;
                wr_cnt <= 4'(WR_HOLD);
            end else if (wr_cnt != 4'd0) begin
                wr_cnt <= wr_cnt - 4'd1;
            end

            frame_err <= bad_stop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected bytes, a monitor
// pops and compares on every wr rising edge.
module tb_uart_rx;

    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned WR_HOLD  = 2;
    localparam int          BITC     = 16;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       wr, frame_err, busy;

    int          errors    = 0;
    int          checks    = 0;
    int          ferr_exp  = 0;
    int          ferr_seen = 0;
    byte unsigned exp_q[$];
    logic [7:0]  last_good = 8'h00;
    logic        wr_prev   = 1'b0;
    int          wr_len    = 0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .WR_HOLD  (WR_HOLD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .wr        (wr),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each delivered byte with the head of the expected queue.
    initial begin
        byte unsigned e;
        forever begin
            @(negedge clk);
            if (frame_err) ferr_seen++;
            if (wr && !wr_prev) begin
                check("wr_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_byte", 32'(data), 32'(e));
                end
                wr_len = 0;
            end
            if (wr) wr_len++;
            if (!wr && wr_prev && rstn) check("wr_width", wr_len, WR_HOLD);
            wr_prev = wr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic v, input int inv_at);
        for (int i = 0; i < BITC; i++) begin
            @(posedge clk);
            #1 rx = (i == inv_at) ? ~v : v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int noise_bit);
        drive_bit(1'b0, -1);
        for (int k = 0; k < 8; k++) begin
            drive_bit(b[k], (k == noise_bit) ? 9 : -1);
            if (k == 0) check("busy_in_frame", 32'(busy), 32'd1);
        end
        drive_bit(stop_v, -1);
    endtask

    task automatic send_good(input logic [7:0] b, input int noise_bit);
        exp_q.push_back(b);
        send_frame(b, 1'b1, noise_bit);
        last_good = b;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] rst_byte;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(data), 32'h00);
        check("reset_wr", 32'(wr), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        idle(10);

        // Single frame
        send_good(8'h43, -1);
        idle(2);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("data_hold_43", 32'(data), 32'h43);

        // Back-to-back, zero idle between frames
        send_good(8'h41, -1);
        send_good(8'h44, -1);
        idle(2);
        check("data_b2b", 32'(data), 32'h44);

        // Short low glitch must be rejected
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
        idle(2);
        check("busy_glitch_start", 32'(busy), 32'd1);
        idle(30);
        check("busy_after_glitch", 32'(busy), 32'd0);

        // Bad stop bit followed by a long break
        send_frame(8'h55, 1'b0, -1);
        ferr_exp++;
        for (int i = 0; i < 40 * BITC; i++) begin
            @(posedge clk);
            #1 rx = 1'b0;
        end
        check("busy_in_break", 32'(busy), 32'd1);
        check("data_kept_break", 32'(data), 32'(last_good));
        check("ferr_count_break", ferr_seen, ferr_exp);
        idle(20);
        check("busy_after_break", 32'(busy), 32'd0);
        send_good(8'h42, -1);
        idle(4);

        // Single-cycle noise inside bit 3
        send_good(8'hA5, 3);
        idle(4);

        // Reset in the middle of a frame
        rst_byte = 8'hF0;
        drive_bit(1'b0, -1);
        for (int k = 0; k < 4; k++) drive_bit(rst_byte[k], -1);
        idle(4);
        rstn = 1'b0;
        idle(2);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_wr", 32'(wr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        last_good = 8'h00;
        rstn = 1'b1;
        idle(4 * BITC);
        check("busy_after_rst", 32'(busy), 32'd0);
        send_good(8'h44, -1);

        // Random bytes with random (possibly zero) gaps
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            send_good(b, -1);
            idle($urandom_range(0, 3) * 5);
        end

        idle(40);
        check("queue_drained", exp_q.size(), 0);
        check("ferr_total", ferr_seen, ferr_exp);
        check("data_final", 32'(data), 32'(last_good));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
